banked_mem_ctrl: RTL and testbench

Parametrised banked memory with a handshaked data port and a registered instruction-fetch port. Indirect (pointer-through-memory) reads and writes run as a sequenced two-step access instead of a chained combinational read. The block sits between the CPU datapath and the unified instruction/data store. Bank 0 holds instructions; banks 1..NUM_BANKS-1 hold data.

---
 rtl/banked_mem_pkg.sv | 30 +++
 rtl/banked_mem_ctrl_bank.sv | 46 ++++
 rtl/banked_mem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_banked_mem_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg: shared types and address-decode helpers for banked_mem_ctrl.
//   state_t       - data-port sequencer states
//   BANK_SEL_W    - bank-select width for the default geometry
//   WORD_SEL_W    - word-select width for the default geometry
//   bank_of()     - bank index from a byte address (top clog2(NUM_BANKS) bits)
//   word_of()     - word index within a bank (byte address bits above bit 0)
package banked_mem_pkg;

    localparam int DEF_NUM_BANKS  = 4;
    localparam int DEF_BANK_WORDS = 512;
    localparam int BANK_SEL_W     = $clog2(DEF_NUM_BANKS);
    localparam int WORD_SEL_W     = $clog2(DEF_BANK_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Callers size-cast the result to their own select width.
    function automatic int unsigned bank_of(input logic [31:0] addr, input int addr_w,
                                            input int bank_w);
        return (addr >> (addr_w - bank_w)) & ((32'd1 << bank_w) - 32'd1);
    endfunction

    function automatic int unsigned word_of(input logic [31:0] addr, input int word_w);
        return (addr >> 1) & ((32'd1 << word_w) - 32'd1);
    endfunction

endpackage

// File: rtl/banked_mem_ctrl_bank.sv
// mem_bank: one bank of the unified store.
//   clk, rst          - clock; async active-high reset clears only the read registers
//   d_en/d_we/d_word  - data port: synchronous read/write, read register updated when d_en
//   d_wdata, d_rdata  - data port write data / registered read data
//   i_word, i_rdata   - instruction port: synchronous read every cycle; on a same-edge
//                       collision with a data write it returns the pre-write word
// Array contents are not reset.
module mem_bank #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 512,
    parameter int WORD_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_en,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_word,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    input  logic [WORD_W-1:0] i_word,
    output logic [DATA_W-1:0] i_rdata
);

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] i_rdata_q;

    always_ff @(posedge clk) begin
        if (d_en && d_we) mem[d_word] <= d_wdata;
    end

    // Non-blocking reads of mem see the value from before this edge's write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdata_q <= '0;
            i_rdata_q <= '0;
        end else begin
            if (d_en) d_rdata_q <= mem[d_word];
            i_rdata_q <= mem[i_word];
        end
    end

    assign d_rdata = d_rdata_q;
    assign i_rdata = i_rdata_q;

endmodule

// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: banked instruction/data store with a handshaked data port and a
// registered instruction-fetch port. Bank 0 holds instructions.
//   clk, rst                          - clock, async active-high reset
//   req_valid/req_ready               - data request handshake
//   req_addr/req_write/req_indirect   - byte address, write flag, pointer-through-memory
//   req_wdata                         - write data
//   rsp_valid/rsp_rdata/rsp_err       - one-cycle response; data/err hold between pulses
//   instr_addr/instr_data             - fetch address, registered fetched word
// Build option: define BANKED_MEM_WP_EN to drop data-port writes to bank 0 and flag
// them with rsp_err; otherwise bank 0 is writable and rsp_err stays 0.
module banked_mem_ctrl
    import banked_mem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int BANK_WORDS = DEF_BANK_WORDS,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic              req_indirect,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_data
);

    localparam int BSEL_W = $clog2(NUM_BANKS);
    localparam int WSEL_W = $clog2(BANK_WORDS);

    state_t state_q, state_d;
    // Bank whose data-port read register feeds the pointer (in PTR) or the response.
    logic [BSEL_W-1:0] bank_q, bank_d;
    logic              rd_q, rd_d;        // response carries read data
    logic              wr_q, wr_d;        // pending indirect op is a write
    logic [DATA_W-1:0] wdata_q, wdata_d;  // pending indirect write data
    logic              err_q, err_d;
    logic [DATA_W-1:0] hold_q, hold_d;    // last driven rsp_rdata
    logic [BSEL_W-1:0] ibank_q, ibank_d;

    logic [NUM_BANKS-1:0][DATA_W-1:0] d_rdata, i_rdata;
    logic [NUM_BANKS-1:0]             d_en;
    logic                             d_we;
    logic [WSEL_W-1:0]                d_word, i_word;
    logic [DATA_W-1:0]                d_wdata;

    logic              accept;
    logic [DATA_W-1:0] sel_rdata;
    logic [ADDR_W-1:0] eff_addr;
    logic [BSEL_W-1:0] req_bank, eff_bank;
    logic [WSEL_W-1:0] req_word, eff_word;
    logic              req_wp, eff_wp;

    assign req_ready = (state_q != PTR);
    // No memory side effects while reset is held.
    assign accept    = req_valid && req_ready && !rst;
    assign sel_rdata = d_rdata[bank_q];
    // Only the low ADDR_W bits of a pointer word are an address.
    assign eff_addr  = ADDR_W'(sel_rdata);

    assign req_bank = BSEL_W'(bank_of(32'(req_addr), ADDR_W, BSEL_W));
    assign req_word = WSEL_W'(word_of(32'(req_addr), WSEL_W));
    assign eff_bank = BSEL_W'(bank_of(32'(eff_addr), ADDR_W, BSEL_W));
    assign eff_word = WSEL_W'(word_of(32'(eff_addr), WSEL_W));
    assign i_word   = WSEL_W'(word_of(32'(instr_addr), WSEL_W));
    assign ibank_d  = BSEL_W'(bank_of(32'(instr_addr), ADDR_W, BSEL_W));

`ifdef BANKED_MEM_WP_EN
    assign req_wp = (req_bank == '0);
    assign eff_wp = (eff_bank == '0);
`else
    assign req_wp = 1'b0;
    assign eff_wp = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        d_en    = '0;
        d_we    = 1'b0;
        d_word  = req_word;
        d_wdata = req_wdata;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    d_en[req_bank] = 1'b1;
                    bank_d         = req_bank;
                    if (req_indirect) begin
                        // Pointer read now; effective access on the way out of PTR.
                        state_d = PTR;
                        wr_d    = req_write;
                        wdata_d = req_wdata;
                    end else begin
                        state_d = RESP;
                        d_we    = req_write && !req_wp;
                        rd_d    = !req_write;
                        err_d   = req_write && req_wp;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PTR: begin
                d_en[eff_bank] = 1'b1;
                d_word         = eff_word;
                d_wdata        = wdata_q;
                d_we           = wr_q && !eff_wp;
                bank_d         = eff_bank;
                rd_d           = !wr_q;
                err_d          = wr_q && eff_wp;
                state_d        = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? (rd_q ? sel_rdata : '0) : hold_q;
    assign hold_d    = rsp_rdata;
    assign rsp_err   = err_q;
    assign instr_data = i_rdata[ibank_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bank_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= '0;
            ibank_q <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            ibank_q <= ibank_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .DATA_W(DATA_W),
            .WORDS (BANK_WORDS),
            .WORD_W(WSEL_W)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .d_en   (d_en[b]),
            .d_we   (d_we),
            .d_word (d_word),
            .d_wdata(d_wdata),
            .d_rdata(d_rdata[b]),
            .i_word (i_word),
            .i_rdata(i_rdata[b])
        );
    end

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Self-checking bench for banked_mem_ctrl: directed scenarios plus randomized traffic
// against a flat word-array model of the store.
module tb_banked_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic        req_indirect = 1'b0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] instr_addr = '0;
    logic [15:0] instr_data;

`ifdef BANKED_MEM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] mdl [0:2047];  // indexed by byte address [11:1]

    banked_mem_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_indirect(req_indirect),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .instr_addr  (instr_addr),
        .instr_data  (instr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Model of one request: returns expected read data and error flag.
    task automatic model(input logic w, input logic ind, input logic [11:0] a,
                         input logic [15:0] wd, output logic [15:0] er, output logic ee);
        logic [11:0] eff;
        logic        wp;
        eff = ind ? mdl[a[11:1]][11:0] : a;
        wp  = WP && w && (eff[11:10] == 2'd0);
        if (w && !wp) mdl[eff[11:1]] = wd;
        er = w ? 16'h0 : mdl[eff[11:1]];
        ee = wp;
    endtask

    task automatic txn(input logic w, input logic ind, input logic [11:0] a,
                       input logic [15:0] wd);
        logic [15:0] er;
        logic        ee;
        logic        seen;
        model(w, ind, a, wd, er, ee);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_indirect = ind; req_addr = a; req_wdata = wd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        seen = 1'b0;
        for (int i = 1; i <= 4 && !seen; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                seen = 1'b1;
                chk("latency", 32'(i), ind ? 32'd2 : 32'd1);
                chk("rsp_rdata", 32'(rsp_rdata), 32'(er));
                chk("rsp_err", 32'(rsp_err), 32'(ee));
            end else if (ind && i == 1) begin
                chk("ready_in_ptr", 32'(req_ready), 32'd0);
            end
        end
        if (!seen) chk("rsp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("pulse_width", 32'(rsp_valid), 32'd0);
        chk("rdata_hold", 32'(rsp_rdata), 32'(er));
        chk("err_hold", 32'(rsp_err), 32'(ee));
    endtask

    function automatic logic [11:0] pick_addr();
        logic [1:0] b;
        logic [2:0] w;
        logic       lsb;
        b   = 2'($urandom_range(0, 3));
        w   = 3'($urandom_range(0, 7));
        lsb = 1'($urandom_range(0, 1));
        return {b, 6'd0, w, lsb};
    endfunction

    initial begin
        logic [15:0] old, er;
        logic        ee;
        logic [11:0] a;
        for (int i = 0; i < 2048; i++) mdl[i] = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_instr", 32'(instr_data), 32'd0);
        rst = 1'b0;

        // Direct and indirect basics
        txn(1'b1, 1'b0, 12'h412, 16'h0018);
        txn(1'b0, 1'b0, 12'h412, 16'h0);
        txn(1'b1, 1'b0, 12'h460, 16'h0412);
        txn(1'b0, 1'b1, 12'h460, 16'h0);
        txn(1'b1, 1'b1, 12'h460, 16'hBEEF);
        txn(1'b0, 1'b0, 12'h412, 16'h0);
        txn(1'b0, 1'b0, 12'h460, 16'h0);

        // Instruction port collision with a data write
        a = 12'h190;
        instr_addr = a;
        @(negedge clk);
        @(negedge clk);
        old = mdl[a[11:1]];
        chk("instr_pre", 32'(instr_data), 32'(old));
        model(1'b1, 1'b0, a, 16'hF190, er, ee);
        req_valid = 1'b1; req_write = 1'b1; req_indirect = 1'b0;
        req_addr = a; req_wdata = 16'hF190;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("instr_collide", 32'(instr_data), 32'(old));
        chk("instr_wr_rsp", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("instr_new", 32'(instr_data), 32'(mdl[a[11:1]]));

        // Back-to-back direct reads
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_indirect = 1'b0; req_addr = 12'h412;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_rsp0_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp0_data", 32'(rsp_rdata), 32'(mdl[12'h412 >> 1]));
        chk("b2b_ready", 32'(req_ready), 32'd1);
        req_addr = 12'h460;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp1_data", 32'(rsp_rdata), 32'(mdl[12'h460 >> 1]));
        @(negedge clk);

        // Reset during PTR of an indirect write: abandoned, no memory update
        req_valid = 1'b1; req_write = 1'b1; req_indirect = 1'b1;
        req_addr = 12'h460; req_wdata = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("ptr_ready_low", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_ptr_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ptr_quiet", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        chk("rst_ptr_ready", 32'(req_ready), 32'd1);
        chk("rst_ptr_rdata", 32'(rsp_rdata), 32'd0);
        txn(1'b0, 1'b0, 12'h412, 16'h0);

        // Write protect of bank 0
        txn(1'b1, 1'b0, 12'h010, 16'h1234);
        txn(1'b0, 1'b0, 12'h010, 16'h0);

        // Randomized traffic on a small address window so pointers and reuse hit often
        for (int n = 0; n < 80; n++) begin
            logic        w, ind;
            logic [15:0] wd;
            w   = 1'($urandom_range(0, 1));
            ind = ($urandom_range(0, 2) == 0);
            wd  = ($urandom_range(0, 1) == 1) ? {4'($urandom_range(0, 15)), pick_addr()}
                                               : 16'($urandom);
            txn(w, ind, pick_addr(), wd);
        end

        // Sweep the window through the instruction port
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 8; w++) begin
                a = {2'(b), 6'd0, 3'(w), 1'b0};
                @(negedge clk);
                instr_addr = a;
                @(negedge clk);
                chk("instr_sweep", 32'(instr_data), 32'(mdl[a[11:1]]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
